// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle control sequencer for the RV32I core
//
// Sequences each instruction through fetch, decode, execute, optional data
// memory access and writeback/PC update. Illegal instructions, ecall/ebreak
// and bus timeouts divert to a one-cycle trap state; wfi parks in WAIT_IRQ.
//
// Ports:
//   clk, rst              core clock, asynchronous active-high reset
//   run                   start/continue, sampled at instruction boundaries
//   imem_ack, dmem_ack    memory handshakes
//   irq                   wake-up from wfi
//   opcode, rd            IR[6:2] and destination register
//   invalid_instruction   decoder illegal flag
//   alu_op, jmp_op, mem_op, csr_op, mechie_op   decoder one-hot/op vectors
//   br_taken              branch compare result
//   imem_req, ir_we, dec_en, alu_en, dmem_req, dmem_we, rf_we, pc_we
//                         datapath strobes and requests
//   pc_sel                0=PC+4, 1=target, 2=trap vector, 3=epc
//   trap, trap_cause      trap strobe and latched cause code
//   instret               retired-instruction counter
//   state                 current state for debug
module cpu_ctrl_fsm #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        imem_ack,
    input  logic        dmem_ack,
    input  logic        irq,
    input  logic [4:0]  opcode,
    input  logic [4:0]  rd,
    input  logic        invalid_instruction,
    input  logic [18:0] alu_op,
    input  logic [8:0]  jmp_op,
    input  logic [8:0]  mem_op,
    input  logic [5:0]  csr_op,
    input  logic [7:0]  mechie_op,
    input  logic        br_taken,
    output logic        imem_req,
    output logic        ir_we,
    output logic        dec_en,
    output logic        alu_en,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        rf_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic        trap,
    output logic [3:0]  trap_cause,
    output logic [31:0] instret,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_DECODE   = 3'd2,
        S_EXEC     = 3'd3,
        S_MEM      = 3'd4,
        S_WB       = 3'd5,
        S_TRAP     = 3'd6,
        S_WAIT_IRQ = 3'd7
    } state_t;

    localparam logic [3:0] CAUSE_IFETCH  = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL = 4'd2;
    localparam logic [3:0] CAUSE_EBREAK  = 4'd3;
    localparam logic [3:0] CAUSE_LOAD    = 4'd5;
    localparam logic [3:0] CAUSE_STORE   = 4'd7;
    localparam logic [3:0] CAUSE_ECALL   = 4'd11;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        trap_cause_q, trap_cause_d;
    logic [31:0]       instret_q, instret_d;

    // The counter holds the number of cycles already waited, so the request
    // has been outstanding for TIMEOUT cycles when it reads TIMEOUT-1 and
    // the current cycle still has no ack.
    logic              cnt_hit;
    logic              is_store;
    logic              rd_writer;

    // Decoder fields the sequencer does not need to inspect.
    logic              unused_inputs;
    assign unused_inputs = ^{alu_op, jmp_op, mem_op[0], mechie_op[7:6], mechie_op[3]};

    assign cnt_hit  = (cnt_q == CNT_W'(TIMEOUT - 1));
    assign is_store = |mem_op[8:6];

    // Opcodes that produce a register result; SYSTEM only for CSR accesses.
    always_comb begin
        rd_writer = 1'b0;
        case (opcode)
            5'b00100, 5'b01100, 5'b01101, 5'b00101,
            5'b11011, 5'b11001, 5'b00000: rd_writer = 1'b1;
            5'b11100:                     rd_writer = |csr_op;
            default:                      rd_writer = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        trap_cause_d = trap_cause_q;
        instret_d    = instret_q;
        imem_req     = 1'b0;
        ir_we        = 1'b0;
        dec_en       = 1'b0;
        alu_en       = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        rf_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'd0;
        trap         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end

            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_we   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_DECODE;
                end else if (cnt_hit) begin
                    cnt_d        = '0;
                    trap_cause_d = CAUSE_IFETCH;
                    state_d      = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_DECODE: begin
                dec_en = 1'b1;
                if (invalid_instruction) begin
                    trap_cause_d = CAUSE_ILLEGAL;
                    state_d      = S_TRAP;
                end else if (mechie_op[1]) begin
                    trap_cause_d = CAUSE_ECALL;
                    state_d      = S_TRAP;
                end else if (mechie_op[0]) begin
                    trap_cause_d = CAUSE_EBREAK;
                    state_d      = S_TRAP;
                end else if (mechie_op[5]) begin
                    state_d = S_WAIT_IRQ;
                end else begin
                    state_d = S_EXEC;
                end
            end

            S_EXEC: begin
                alu_en  = 1'b1;
                state_d = (|mem_op[8:1]) ? S_MEM : S_WB;
            end

            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
                if (dmem_ack) begin
                    cnt_d = '0;
                    if (is_store) begin
                        // Stores have no writeback, so they retire here.
                        pc_we     = 1'b1;
                        instret_d = instret_q + 32'd1;
                        state_d   = run ? S_FETCH : S_IDLE;
                    end else begin
                        state_d = S_WB;
                    end
                end else if (cnt_hit) begin
                    cnt_d        = '0;
                    trap_cause_d = is_store ? CAUSE_STORE : CAUSE_LOAD;
                    state_d      = S_TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WB: begin
                pc_we     = 1'b1;
                instret_d = instret_q + 32'd1;
                rf_we     = rd_writer && (rd != 5'd0);
                if ((opcode == 5'b11011) || (opcode == 5'b11001) ||
                    ((opcode == 5'b11000) && br_taken)) begin
                    pc_sel = 2'd1;
                end else if (mechie_op[2] || mechie_op[4]) begin
                    pc_sel = 2'd3;
                end
                state_d = run ? S_FETCH : S_IDLE;
            end

            S_TRAP: begin
                trap    = 1'b1;
                pc_we   = 1'b1;
                pc_sel  = 2'd2;
                state_d = run ? S_FETCH : S_IDLE;
            end

            S_WAIT_IRQ: begin
                if (irq) begin
                    pc_we     = 1'b1;
                    instret_d = instret_q + 32'd1;
                    state_d   = S_FETCH;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            trap_cause_q <= 4'd0;
            instret_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            trap_cause_q <= trap_cause_d;
            instret_q    <= instret_d;
        end
    end

    assign trap_cause = trap_cause_q;
    assign instret    = instret_q;
    assign state      = state_q;

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// tb/tb_cpu_ctrl_fsm.sv - directed self-checking bench for cpu_ctrl_fsm
module tb_cpu_ctrl_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic        imem_ack;
    logic        dmem_ack;
    logic        irq;
    logic [4:0]  opcode;
    logic [4:0]  rd;
    logic        invalid_instruction;
    logic [18:0] alu_op;
    logic [8:0]  jmp_op;
    logic [8:0]  mem_op;
    logic [5:0]  csr_op;
    logic [7:0]  mechie_op;
    logic        br_taken;
    logic        imem_req;
    logic        ir_we;
    logic        dec_en;
    logic        alu_en;
    logic        dmem_req;
    logic        dmem_we;
    logic        rf_we;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic        trap;
    logic [3:0]  trap_cause;
    logic [31:0] instret;
    logic [2:0]  state;

    int checks = 0;
    int errors = 0;

    cpu_ctrl_fsm #(.TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .rst(rst), .run(run), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
        .irq(irq), .opcode(opcode), .rd(rd), .invalid_instruction(invalid_instruction),
        .alu_op(alu_op), .jmp_op(jmp_op), .mem_op(mem_op), .csr_op(csr_op),
        .mechie_op(mechie_op), .br_taken(br_taken), .imem_req(imem_req), .ir_we(ir_we),
        .dec_en(dec_en), .alu_en(alu_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel), .trap(trap),
        .trap_cause(trap_cause), .instret(instret), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change 2 time units after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_instr(input logic [4:0] op, input logic [4:0] r, input logic [8:0] m,
                             input logic [7:0] sys, input logic ill, input logic bt);
        opcode = op; rd = r; mem_op = m; mechie_op = sys;
        invalid_instruction = ill; br_taken = bt;
        csr_op = 6'd0; alu_op = 19'd0; jmp_op = 9'd0;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; imem_ack = 1'b0; dmem_ack = 1'b0; irq = 1'b0;
        set_instr(5'd0, 5'd0, 9'd0, 8'd0, 1'b0, 1'b0);
        tick(); settle();
        chk("reset_state", 32'(state), 32'd0);
        chk("reset_imem_req", 32'(imem_req), 32'd0);
        chk("reset_pc_sel", 32'(pc_sel), 32'd0);
        chk("reset_instret", instret, 32'd0);
        chk("reset_cause", 32'(trap_cause), 32'd0);
        rst = 1'b0; run = 1'b1;

        // addi x1
        tick(); settle();
        chk("addi_fetch_state", 32'(state), 32'd1);
        set_instr(5'b00100, 5'd1, 9'd0, 8'd0, 1'b0, 1'b0);
        imem_ack = 1'b1; settle();
        chk("addi_imem_req", 32'(imem_req), 32'd1);
        chk("addi_ir_we", 32'(ir_we), 32'd1);
        tick(); imem_ack = 1'b0; settle();
        chk("addi_decode", 32'({state, dec_en}), 32'({3'd2, 1'b1}));
        tick(); settle();
        chk("addi_exec", 32'({state, alu_en, dec_en}), 32'({3'd3, 1'b1, 1'b0}));
        tick(); settle();
        chk("addi_wb", 32'({state, rf_we, pc_we, pc_sel}), 32'({3'd5, 1'b1, 1'b1, 2'd0}));
        tick(); settle();
        chk("addi_back_fetch", 32'(state), 32'd1);
        chk("addi_instret", instret, 32'd1);

        // lw x5, ack after 3 waiting cycles
        set_instr(5'b00000, 5'd5, 9'b000000100, 8'd0, 1'b0, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick();
        tick(); settle();
        for (int i = 0; i < 3; i++) begin
            chk("lw_mem_wait", 32'({state, dmem_req, dmem_we}), 32'({3'd4, 1'b1, 1'b0}));
            tick();
        end
        dmem_ack = 1'b1; settle();
        chk("lw_mem_ack", 32'({dmem_req, dmem_we, pc_we}), 32'({1'b1, 1'b0, 1'b0}));
        tick(); dmem_ack = 1'b0; settle();
        chk("lw_wb", 32'({state, rf_we, pc_we, pc_sel}), 32'({3'd5, 1'b1, 1'b1, 2'd0}));
        tick(); settle();
        chk("lw_instret", instret, 32'd2);

        // beq taken, then not taken; rd field nonzero must not write
        for (int t = 1; t >= 0; t--) begin
            set_instr(5'b11000, 5'd3, 9'd0, 8'd0, 1'b0, t[0]);
            imem_ack = 1'b1;
            tick(); imem_ack = 1'b0;
            tick();
            tick(); settle();
            chk("beq_wb", 32'({state, rf_we, pc_we, pc_sel}), 32'({3'd5, 1'b0, 1'b1, 2'(t)}));
            tick();
        end
        settle();
        chk("beq_instret", instret, 32'd4);

        // illegal instruction
        set_instr(5'b00100, 5'd1, 9'd0, 8'd0, 1'b1, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick(); settle();
        chk("ill_trap", 32'({state, trap, pc_we, pc_sel, trap_cause}),
            32'({3'd6, 1'b1, 1'b1, 2'd2, 4'd2}));
        chk("ill_instret", instret, 32'd4);
        tick(); settle();
        chk("ill_after", 32'({state, trap}), 32'({3'd1, 1'b0}));
        chk("ill_instret_after", instret, 32'd4);

        // fetch timeout: 16 cycles without ack
        set_instr(5'b00100, 5'd1, 9'd0, 8'd0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        settle();
        chk("ifto_16th_cycle", 32'(state), 32'd1);
        tick(); settle();
        chk("ifto_trap", 32'({state, trap, trap_cause}), 32'({3'd6, 1'b1, 4'd1}));
        tick(); settle();

        // ack on the 16th cycle wins; instruction is wfi
        set_instr(5'b11100, 5'd0, 9'd0, 8'b0010_0000, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) tick();
        imem_ack = 1'b1; settle();
        chk("if16_ack_ir_we", 32'({state, ir_we}), 32'({3'd1, 1'b1}));
        tick(); imem_ack = 1'b0; settle();
        chk("if16_decode", 32'(state), 32'd2);
        tick(); settle();
        for (int i = 0; i < 10; i++) begin
            chk("wfi_wait", 32'({state, pc_we, imem_req}), 32'({3'd7, 1'b0, 1'b0}));
            tick(); settle();
        end
        irq = 1'b1; settle();
        chk("wfi_irq", 32'({pc_we, pc_sel}), 32'({1'b1, 2'd0}));
        tick(); irq = 1'b0; settle();
        chk("wfi_fetch", 32'(state), 32'd1);
        chk("wfi_instret", instret, 32'd5);

        // mret returns through epc
        set_instr(5'b11100, 5'd0, 9'd0, 8'b0000_0100, 1'b0, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick();
        tick(); settle();
        chk("mret_wb", 32'({state, rf_we, pc_sel}), 32'({3'd5, 1'b0, 2'd3}));
        tick();

        // ecall, run dropped during trap -> IDLE
        set_instr(5'b11100, 5'd0, 9'd0, 8'b0000_0010, 1'b0, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick(); settle();
        chk("ecall_trap", 32'({state, trap_cause}), 32'({3'd6, 4'd11}));
        run = 1'b0;
        tick(); settle();
        chk("ecall_idle", 32'(state), 32'd0);
        chk("ecall_instret", instret, 32'd6);

        // store, run dropped mid-instruction, stops after the store retires
        run = 1'b1;
        tick();
        set_instr(5'b01000, 5'd0, 9'b001000000, 8'd0, 1'b0, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0; run = 1'b0;
        tick();
        tick(); settle();
        chk("sw_mem", 32'({state, dmem_req, dmem_we}), 32'({3'd4, 1'b1, 1'b1}));
        dmem_ack = 1'b1; settle();
        chk("sw_ack", 32'({pc_we, pc_sel, rf_we}), 32'({1'b1, 2'd0, 1'b0}));
        tick(); dmem_ack = 1'b0; settle();
        chk("sw_idle", 32'(state), 32'd0);
        chk("sw_instret", instret, 32'd7);

        // reset during MEM drops the request immediately
        run = 1'b1;
        tick();
        set_instr(5'b00000, 5'd5, 9'b000000100, 8'd0, 1'b0, 1'b0);
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick();
        tick(); settle();
        chk("rst_mem_before", 32'({state, dmem_req}), 32'({3'd4, 1'b1}));
        rst = 1'b1; settle();
        chk("rst_mem_after", 32'({state, dmem_req}), 32'({3'd0, 1'b0}));
        chk("rst_instret", instret, 32'd0);
        tick(); rst = 1'b0;

        // load timeout -> cause 5
        tick();
        imem_ack = 1'b1;
        tick(); imem_ack = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 15; i++) tick();
        settle();
        chk("ldto_16th_cycle", 32'(state), 32'd4);
        tick(); settle();
        chk("ldto_trap", 32'({state, trap, trap_cause}), 32'({3'd6, 1'b1, 4'd5}));
        chk("ldto_instret", instret, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
